// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared encodings for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] c_owner_idle = 2'b00;
    localparam logic [1:0] c_owner_p0   = 2'b01;
    localparam logic [1:0] c_owner_p1   = 2'b10;

    localparam logic c_port0 = 1'b0;
    localparam logic c_port1 = 1'b1;

    function automatic arb_state_e port_state(input logic port);
        return (port == c_port1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin picker; on a tie the port that is not
//               'last' wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick,
    output logic any
);

    assign any  = req0 | req1;
    assign pick = (req0 & req1) ? ~last : req1;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter with bounded locked bursts sharing one
//               single-port data memory between core (port 0) and host (port 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              mem_e,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int              BEAT_W      = $clog2(MAX_BURST) + 1;
    localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(MAX_BURST - 1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;

    logic w_own0;
    logic w_own1;
    logic w_gnt;
    logic w_port;
    logic w_lock_x;
    logic w_stay;
    logic w_release;
    logic w_pick_req0;
    logic w_pick_req1;
    logic w_pick;
    logic w_any;

    always_comb begin
        w_own0    = (state_q == ST_OWN0);
        w_own1    = (state_q == ST_OWN1);
        gnt0      = w_own0 & req0;
        gnt1      = w_own1 & req1;
        w_gnt     = gnt0 | gnt1;
        w_port    = w_own1 ? c_port1 : c_port0;
        w_lock_x  = w_own1 ? lock1 : lock0;
        w_stay    = w_gnt & w_lock_x & (beat_q < c_beat_last);
        // An owner that did not stay (cap, lock dropped or request dropped) releases.
        w_release = (state_q != ST_IDLE) & ~w_stay;
        last_d    = w_release ? w_port : last_q;
        if (w_release) begin
            beat_d = '0;
        end else if (w_gnt) begin
            beat_d = beat_q + BEAT_W'(1);
        end else begin
            beat_d = beat_q;
        end
        // On release the current owner only competes for a fresh locked burst,
        // with last_d already pointing at it so the other port wins any tie.
        w_pick_req0 = w_own0 ? (req0 & lock0) : req0;
        w_pick_req1 = w_own1 ? (req1 & lock1) : req1;
    end

    rr_pick2 u_pick (
        .req0 (w_pick_req0),
        .req1 (w_pick_req1),
        .last (last_d),
        .pick (w_pick),
        .any  (w_any)
    );

    always_comb begin
        if (w_stay) begin
            state_d = state_q;
        end else if (w_any) begin
            state_d = port_state(w_pick);
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        mem_e     = w_gnt;
        mem_we    = (gnt0 & we0) | (gnt1 & we1);
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end

        if (w_own0) begin
            owner = c_owner_p0;
        end else if (w_own1) begin
            owner = c_owner_p1;
        end else begin
            owner = c_owner_idle;
        end

        rvalid0_d = gnt0 & ~we0;
        rvalid1_d = gnt1 & ~we1;
        rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= c_port1;
            beat_q    <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter against a transaction-level
//               ownership/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int MB = 4;
    localparam logic [7:0] INIT_MEM [16] = '{8'h01, 8'h1E, 8'h3B, 8'h58, 8'h75, 8'h92, 8'hAF, 8'hCC,
                                             8'hE9, 8'h06, 8'h23, 8'h40, 8'h5D, 8'h7A, 8'h97, 8'hB4};

    typedef struct {
        logic       req;
        logic       we;
        logic       lock;
        logic [3:0] addr;
        logic [7:0] wdata;
    } pin_t;

    typedef struct {
        logic       g0, g1;
        logic [1:0] own;
        logic       e, we;
        logic [3:0] a;
        logic [7:0] d;
        logic       rv0, rv1;
        logic [7:0] rd0, rd1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [3:0] addr0, addr1, mem_addr;
    logic [7:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_e, mem_we;
    logic [1:0] owner;

    logic [7:0] tb_mem [16] = INIT_MEM;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: who owns the memory, beats used in this tenure, last releaser
    int         m_own;
    int         m_used;
    int         m_last;
    logic       m_rv [2];
    logic [7:0] m_rd [2];
    logic [7:0] ref_mem [16] = INIT_MEM;
    logic       pg [2];
    pin_t       cp [2];

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_e(mem_e), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) if (mem_e && mem_we) tb_mem[mem_addr] <= mem_wdata;

    function automatic pin_t mk(input logic r, input logic w, input logic l,
                                input logic [3:0] a, input logic [7:0] d);
        pin_t p;
        p.req = r; p.we = w; p.lock = l; p.addr = a; p.wdata = d;
        return p;
    endfunction

    task automatic model_reset();
        m_own = 0; m_used = 0; m_last = 1;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = 8'h00; m_rd[1] = 8'h00;
    endtask

    function automatic exp_t predict(input pin_t p0, input pin_t p1);
        exp_t e;
        e.g0  = (m_own == 1) && p0.req;
        e.g1  = (m_own == 2) && p1.req;
        e.own = 2'(m_own);
        e.e   = e.g0 || e.g1;
        e.we  = (e.g0 && p0.we) || (e.g1 && p1.we);
        e.a   = e.g0 ? p0.addr  : (e.g1 ? p1.addr  : 4'h0);
        e.d   = e.g0 ? p0.wdata : (e.g1 ? p1.wdata : 8'h00);
        e.rv0 = m_rv[0]; e.rv1 = m_rv[1];
        e.rd0 = m_rd[0]; e.rd1 = m_rd[1];
        return e;
    endfunction

    task automatic model_update(input pin_t p0, input pin_t p1);
        pin_t p [2];
        logic g [2];
        int   x;
        if (rst) begin
            model_reset();
            return;
        end
        p[0] = p0; p[1] = p1;
        for (int i = 0; i < 2; i++) begin
            g[i]    = (m_own == i + 1) && p[i].req;
            m_rv[i] = g[i] && !p[i].we;
            if (m_rv[i]) m_rd[i] = ref_mem[p[i].addr];
            if (g[i] && p[i].we) ref_mem[p[i].addr] = p[i].wdata;
        end
        if (m_own == 0) begin
            if (p[0].req && p[1].req) m_own = (m_last == 1) ? 1 : 2;
            else if (p[0].req)        m_own = 1;
            else if (p[1].req)        m_own = 2;
        end else begin
            x = m_own - 1;
            if (g[x]) m_used++;
            if (!(g[x] && p[x].lock && m_used < MB)) begin
                m_last = x;
                m_used = 0;
                if (p[1-x].req)                m_own = 2 - x;
                else if (p[x].req && p[x].lock) m_own = x + 1;
                else                            m_own = 0;
            end
        end
    endtask

    task automatic drive(input pin_t p0, input pin_t p1);
        req0 = p0.req; we0 = p0.we; lock0 = p0.lock; addr0 = p0.addr; wdata0 = p0.wdata;
        req1 = p1.req; we1 = p1.we; lock1 = p1.lock; addr1 = p1.addr; wdata1 = p1.wdata;
    endtask

    task automatic cycle(input pin_t p0, input pin_t p1);
        exp_t e;
        drive(p0, p1);
        e = predict(p0, p1);
        pg[0] = e.g0; pg[1] = e.g1;
        exp_q.push_back(e);
        @(posedge clk);
        model_update(p0, p1);
        #1;
    endtask

    // Asserts reset between the sampling edge and the next clock edge of a cycle.
    task automatic cycle_rst(input pin_t p0, input pin_t p1);
        drive(p0, p1);
        exp_q.push_back(predict(p0, p1));
        @(negedge clk);
        #2;
        model_reset();
        exp_q.push_back(predict(p0, p1));
        rst = 1'b1;
        @(posedge clk);
        model_update(p0, p1);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("arb gnt0/gnt1/owner", {29'd0, gnt0, gnt1, owner}, {29'd0, e.g0, e.g1, e.own});
                chk("mem e/we/addr/wdata", {18'd0, mem_e, mem_we, mem_addr, mem_wdata},
                    {18'd0, e.e, e.we, e.a, e.d});
                chk("port0 rvalid/rdata", {23'd0, rvalid0, rdata0}, {23'd0, e.rv0, e.rd0});
                chk("port1 rvalid/rdata", {23'd0, rvalid1, rdata1}, {23'd0, e.rv1, e.rd1});
            end
        end
    end

    initial begin : stim
        pin_t idle, np;
        idle = mk(0, 0, 0, 4'h0, 8'h00);
        rst  = 1'b1;
        model_reset();
        repeat (2) cycle(idle, idle);
        rst = 1'b0;
        cycle(idle, idle);

        // Single write request: grant one cycle after request
        cycle(mk(1, 1, 0, 4'd3, 8'hA5), idle);
        cycle(mk(1, 1, 0, 4'd3, 8'hA5), idle);
        cycle(idle, idle);

        // Tie from idle, then handover without a bubble
        cycle(mk(1, 0, 0, 4'd1, 8'h00), mk(1, 0, 0, 4'd2, 8'h00));
        cycle(mk(1, 0, 0, 4'd1, 8'h00), mk(1, 0, 0, 4'd2, 8'h00));
        cycle(idle, mk(1, 0, 0, 4'd2, 8'h00));
        cycle(idle, idle);

        // Locked burst capped at MAX_BURST beats while port 1 waits
        repeat (6) cycle(mk(1, 0, 1, 4'd4, 8'h00), mk(1, 0, 0, 4'd5, 8'h00));
        repeat (3) cycle(idle, idle);

        // Write on port 1, read-back on port 0 right after
        cycle(idle, mk(1, 1, 0, 4'd7, 8'h3C));
        cycle(mk(1, 0, 0, 4'd7, 8'h00), mk(1, 1, 0, 4'd7, 8'h3C));
        cycle(mk(1, 0, 0, 4'd7, 8'h00), idle);
        cycle(idle, idle);
        cycle(idle, idle);

        // Reset in the middle of a locked burst, then tie goes to port 0
        repeat (3) cycle(mk(1, 0, 1, 4'd2, 8'h00), idle);
        cycle_rst(mk(1, 0, 1, 4'd2, 8'h00), mk(1, 0, 0, 4'd6, 8'h00));
        cycle(mk(1, 0, 0, 4'd2, 8'h00), mk(1, 0, 0, 4'd6, 8'h00));
        rst = 1'b0;
        cycle(mk(1, 0, 0, 4'd2, 8'h00), mk(1, 0, 0, 4'd6, 8'h00));
        cycle(mk(1, 0, 0, 4'd2, 8'h00), mk(1, 0, 0, 4'd6, 8'h00));
        cycle(idle, mk(1, 0, 0, 4'd6, 8'h00));
        repeat (2) cycle(idle, idle);

        // Port 1 drops its request mid-burst while port 0 waits
        cycle(idle, mk(1, 1, 1, 4'd9, 8'h11));
        cycle(mk(1, 0, 0, 4'd9, 8'h00), mk(1, 1, 1, 4'd9, 8'h11));
        cycle(mk(1, 0, 0, 4'd9, 8'h00), mk(0, 0, 1, 4'd9, 8'h22));
        cycle(mk(1, 0, 0, 4'd9, 8'h00), idle);
        repeat (2) cycle(idle, idle);

        // Randomized traffic obeying the hold-until-grant handshake
        cp[0] = idle; cp[1] = idle;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (cp[i].req && !pg[i]) begin
                    np = cp[i];
                end else if (cp[i].req && cp[i].lock && ($urandom_range(0, 9) != 0)) begin
                    np = mk(1, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
                            4'($urandom_range(0, 5)), 8'($urandom));
                end else if ($urandom_range(0, 1) == 1) begin
                    np = mk(1, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4,
                            4'($urandom_range(0, 15)), 8'($urandom));
                end else begin
                    np = mk(0, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom), 8'($urandom));
                end
                cp[i] = np;
            end
            cycle(cp[0], cp[1]);
        end

        repeat (3) cycle(idle, idle);
        @(negedge clk);
        #3;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
